// File: rtl/uart_rx_frame.sv
// UART frame receiver: 2-flop synchroniser, start/8 data LSB-first/even parity/stop, sampled mid-bit.
// Byte, frame and strobes are registered one cycle after the stop sample; there is no backpressure.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  output logic [7:0] rx_data,
  output logic [8:0] rx_frame,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       stop_err,
  output logic       fault,
  output logic       busy
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        r_state;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [7:0]    r_rx_data;
  logic [8:0]    r_rx_frame;
  logic          r_rx_valid;
  logic          r_parity_err;
  logic          r_stop_err;
  logic          r_fault;
  logic          r_busy;

  logic w_rx_s;
  logic w_perr;
  logic w_serr;

  assign w_rx_s = r_sync[1];
  assign w_perr = r_par ^ (^r_shift);
  assign w_serr = ~w_rx_s;

  assign rx_data    = r_rx_data;
  assign rx_frame   = r_rx_frame;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_parity_err;
  assign stop_err   = r_stop_err;
  assign fault      = r_fault;
  assign busy       = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], Rx};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_rx_data    <= '0;
      r_rx_frame   <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_stop_err   <= 1'b0;
      r_fault      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_stop_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_bit_cnt <= '0;
            r_cnt     <= '0;
            r_state   <= START;
            r_busy    <= 1'b1;
          end
        end
        START: begin
          // A line that is high again at mid start bit was a glitch.
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state <= DATA;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= PARITY;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_par   <= w_rx_s;
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          // Return to IDLE straight after the stop sample so a back-to-back start edge is caught.
          if (r_cnt == BIT_LAST) begin
            r_cnt        <= '0;
            r_rx_data    <= r_shift;
            r_rx_frame   <= {r_par, r_shift};
            r_rx_valid   <= ~(w_perr | w_serr);
            r_parity_err <= w_perr;
            r_stop_err   <= w_serr;
            r_fault      <= w_perr | w_serr;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
